// File: rtl/dispatch_pkg.sv
// Shared types and constants for the dual-issue pair dispatcher.
package dispatch_pkg;

    localparam int unsigned REG_W_DEF     = 4;
    localparam int unsigned PAYLOAD_W_DEF = 32;
    localparam int unsigned CNT_W         = 16;

    typedef struct packed {
        logic                     valid;
        logic [REG_W_DEF-1:0]     des;
        logic [REG_W_DEF-1:0]     s1;
        logic [REG_W_DEF-1:0]     s2;
        logic [PAYLOAD_W_DEF-1:0] pay;
    } slot_t;

    typedef enum logic [1:0] {EMPTY, HOLD, SECOND} disp_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dual_issue_pair_dispatcher_if.sv
// Issue-queue and execute-lane signals of the pair dispatcher; master drives, slave is the DUT.
interface dual_issue_pair_dispatcher_if
    import dispatch_pkg::*;
#(
    parameter int unsigned REG_W     = REG_W_DEF,
    parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic                 i0_valid;
    logic                 i1_valid;
    logic [REG_W-1:0]     i0_des;
    logic [REG_W-1:0]     i0_s1;
    logic [REG_W-1:0]     i0_s2;
    logic [REG_W-1:0]     i1_des;
    logic [REG_W-1:0]     i1_s1;
    logic [REG_W-1:0]     i1_s2;
    logic [PAYLOAD_W-1:0] i0_pay;
    logic [PAYLOAD_W-1:0] i1_pay;
    logic                 out_ready;
    logic                 out0_valid;
    logic [PAYLOAD_W-1:0] out0_pay;
    logic                 out1_valid;
    logic [PAYLOAD_W-1:0] out1_pay;

    modport master (
        output flush, in_valid, i0_valid, i1_valid, i0_des, i0_s1, i0_s2,
               i1_des, i1_s1, i1_s2, i0_pay, i1_pay, out_ready,
        input  in_ready, out0_valid, out0_pay, out1_valid, out1_pay
    );

    modport slave (
        input  flush, in_valid, i0_valid, i1_valid, i0_des, i0_s1, i0_s2,
               i1_des, i1_s1, i1_s2, i0_pay, i1_pay, out_ready,
        output in_ready, out0_valid, out0_pay, out1_valid, out1_pay
    );

endinterface

// File: rtl/pair_dep_compare.sv
// Combinational RAW/WAR/WAW detector between the two slots of a pair; register 0 never conflicts.
module pair_dep_compare #(
    parameter int unsigned REG_W = 4
) (
    input  logic             i_valid0,
    input  logic             i_valid1,
    input  logic [REG_W-1:0] i_des0,
    input  logic [REG_W-1:0] i_s1_0,
    input  logic [REG_W-1:0] i_s2_0,
    input  logic [REG_W-1:0] i_des1,
    input  logic [REG_W-1:0] i_s1_1,
    input  logic [REG_W-1:0] i_s2_1,
    output logic             o_haz
);

    logic w_raw;
    logic w_war;
    logic w_waw;

    assign w_raw = (i_des0 != '0) && ((i_des0 == i_s1_1) || (i_des0 == i_s2_1));
    assign w_war = (i_des1 != '0) && ((i_des1 == i_s1_0) || (i_des1 == i_s2_0));
    assign w_waw = (i_des0 != '0) && (i_des0 == i_des1);

    assign o_haz = i_valid0 && i_valid1 && (w_raw || w_war || w_waw);

endmodule

// File: rtl/dual_issue_pair_dispatcher.sv
// Accepts an instruction pair, dual-issues it when independent, otherwise splits it in order.
// Optional counters split_cnt/pair_cnt exist only when PAIR_DISPATCH_STATS_EN is defined.
module dual_issue_pair_dispatcher
    import dispatch_pkg::*;
#(
    parameter int unsigned REG_W     = REG_W_DEF,
    parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF
) (
    input logic                         clk,
    input logic                         rst,
    dual_issue_pair_dispatcher_if.slave bus
`ifdef PAIR_DISPATCH_STATS_EN
    ,
    output logic [CNT_W-1:0]            split_cnt,
    output logic [CNT_W-1:0]            pair_cnt
`endif
);

    slot_t                w_slot0;
    slot_t                w_slot1;
    logic                 w_haz;
    logic                 w_fire;
    logic                 w_drain;
    logic                 w_in_ready;
    logic                 w_accept;

    disp_state_e          r_state;
    logic                 r_haz;
    logic                 r_out0_valid;
    logic                 r_out1_valid;
    logic [PAYLOAD_W-1:0] r_out0_pay;
    logic [PAYLOAD_W-1:0] r_out1_pay;

    assign w_slot0 = '{valid: bus.i0_valid, des: bus.i0_des, s1: bus.i0_s1, s2: bus.i0_s2,
                       pay: bus.i0_pay};
    assign w_slot1 = '{valid: bus.i1_valid, des: bus.i1_des, s1: bus.i1_s1, s2: bus.i1_s2,
                       pay: bus.i1_pay};

    pair_dep_compare #(
        .REG_W (REG_W)
    ) u_cmp (
        .i_valid0 (w_slot0.valid),
        .i_valid1 (w_slot1.valid),
        .i_des0   (w_slot0.des),
        .i_s1_0   (w_slot0.s1),
        .i_s2_0   (w_slot0.s2),
        .i_des1   (w_slot1.des),
        .i_s1_1   (w_slot1.s1),
        .i_s2_1   (w_slot1.s2),
        .o_haz    (w_haz)
    );

    // r_out0_valid is high exactly when state != EMPTY
    assign w_fire     = r_out0_valid && bus.out_ready;
    // Handshake that finishes all held work, freeing the slot for a new pair this cycle
    assign w_drain    = bus.out_ready && (((r_state == HOLD) && !r_haz) || (r_state == SECOND));
    assign w_in_ready = !bus.flush && ((r_state == EMPTY) || w_drain);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_haz        <= 1'b0;
            r_out0_valid <= 1'b0;
            r_out1_valid <= 1'b0;
            r_out0_pay   <= '0;
            r_out1_pay   <= '0;
        end else if (bus.flush) begin
            r_state      <= EMPTY;
            r_haz        <= 1'b0;
            r_out0_valid <= 1'b0;
            r_out1_valid <= 1'b0;
        end else if (w_accept) begin
            if (w_slot0.valid) begin
                // On a hazard slot1 waits in r_out1_pay with lane 1 invalid
                r_state      <= HOLD;
                r_haz        <= w_haz;
                r_out0_valid <= 1'b1;
                r_out1_valid <= w_slot1.valid && !w_haz;
                r_out0_pay   <= w_slot0.pay;
                r_out1_pay   <= w_slot1.pay;
            end else if (w_slot1.valid) begin
                r_state      <= HOLD;
                r_haz        <= 1'b0;
                r_out0_valid <= 1'b1;
                r_out1_valid <= 1'b0;
                r_out0_pay   <= w_slot1.pay;
            end else begin
                r_state      <= EMPTY;
                r_haz        <= 1'b0;
                r_out0_valid <= 1'b0;
                r_out1_valid <= 1'b0;
            end
        end else if (w_drain) begin
            r_state      <= EMPTY;
            r_haz        <= 1'b0;
            r_out0_valid <= 1'b0;
            r_out1_valid <= 1'b0;
        end else if (bus.out_ready && (r_state == HOLD)) begin
            r_state    <= SECOND;
            r_haz      <= 1'b0;
            r_out0_pay <= r_out1_pay;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out0_valid = r_out0_valid;
    assign bus.out0_pay   = r_out0_pay;
    assign bus.out1_valid = r_out1_valid;
    assign bus.out1_pay   = r_out1_pay;

`ifdef PAIR_DISPATCH_STATS_EN
    logic [CNT_W-1:0] r_split_cnt;
    logic [CNT_W-1:0] r_pair_cnt;

    // Counted on the HOLD handshake: a full pair issue or the first half of a split
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_split_cnt <= '0;
            r_pair_cnt  <= '0;
        end else if (w_fire && (r_state == HOLD)) begin
            if (r_out1_valid) begin
                r_pair_cnt <= sat_inc(r_pair_cnt);
            end
            if (r_haz) begin
                r_split_cnt <= sat_inc(r_split_cnt);
            end
        end
    end

    assign split_cnt = r_split_cnt;
    assign pair_cnt  = r_pair_cnt;
`else
    logic w_unused_fire;
    assign w_unused_fire = w_fire;
`endif

endmodule

// File: tb/tb_dual_issue_pair_dispatcher.sv
// Self-checking bench: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_dual_issue_pair_dispatcher;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic        v0;
        logic        v1;
        logic [3:0]  d0, a0, b0, d1, a1, b1;
        logic [31:0] p0, p1;
        logic        out_ready;
    } in_t;

    typedef struct {
        in_t         x;
        logic        e_o0;
        logic        e_o1;
        logic        e_rdy;
        logic [31:0] e_p0;
        logic [31:0] e_p1;
    } vec_t;

    // One pending output handshake as the execute side should see it
    typedef struct {
        logic        pair;
        logic        split_first;
        logic [31:0] p0;
        logic [31:0] p1;
    } grp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_issue_pair_dispatcher_if #(.REG_W(4), .PAYLOAD_W(32)) bus ();

`ifdef PAIR_DISPATCH_STATS_EN
    logic [15:0] split_cnt;
    logic [15:0] pair_cnt;
`endif

    dual_issue_pair_dispatcher #(
        .REG_W     (4),
        .PAYLOAD_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef PAIR_DISPATCH_STATS_EN
        ,
        .split_cnt (split_cnt),
        .pair_cnt  (pair_cnt)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    grp_t mq[$];
    int   m_pair  = 0;
    int   m_split = 0;
    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t mk_in(input logic iv, input logic v0, input logic v1,
                                  input logic [3:0] d0, input logic [3:0] a0, input logic [3:0] b0,
                                  input logic [3:0] d1, input logic [3:0] a1, input logic [3:0] b1,
                                  input logic [31:0] p0, input logic [31:0] p1,
                                  input logic fl, input logic ordy);
        in_t x;
        x.flush = fl; x.in_valid = iv; x.v0 = v0; x.v1 = v1;
        x.d0 = d0; x.a0 = a0; x.b0 = b0; x.d1 = d1; x.a1 = a1; x.b1 = b1;
        x.p0 = p0; x.p1 = p1; x.out_ready = ordy;
        return x;
    endfunction

    function automatic vec_t mk(input in_t x, input logic o0, input logic o1, input logic rdy,
                                input logic [31:0] ep0, input logic [31:0] ep1);
        vec_t v;
        v.x = x; v.e_o0 = o0; v.e_o1 = o1; v.e_rdy = rdy; v.e_p0 = ep0; v.e_p1 = ep1;
        return v;
    endfunction

    function automatic in_t idle(input logic ordy);
        return mk_in(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0,
                     1'b0, ordy);
    endfunction

    function automatic bit hazard(input in_t x);
        bit raw, war, waw;
        raw = (x.d0 != 0) && (x.d0 == x.a1 || x.d0 == x.b1);
        war = (x.d1 != 0) && (x.d1 == x.a0 || x.d1 == x.b0);
        waw = (x.d0 != 0) && (x.d0 == x.d1);
        return x.v0 && x.v1 && (raw || war || waw);
    endfunction

    // Ready iff at most one issue is outstanding and it completes this cycle
    function automatic bit model_ready(input in_t x);
        return !x.flush && (mq.size() == 0 || (x.out_ready && mq.size() == 1));
    endfunction

    task automatic apply(input in_t x);
        @(negedge clk);
        bus.flush     = x.flush;
        bus.in_valid  = x.in_valid;
        bus.i0_valid  = x.v0;
        bus.i1_valid  = x.v1;
        bus.i0_des    = x.d0;
        bus.i0_s1     = x.a0;
        bus.i0_s2     = x.b0;
        bus.i1_des    = x.d1;
        bus.i1_s1     = x.a1;
        bus.i1_s2     = x.b1;
        bus.i0_pay    = x.p0;
        bus.i1_pay    = x.p1;
        bus.out_ready = x.out_ready;
        #1;
    endtask

    task automatic model_check(input string tag, input in_t x);
        chk({tag, "_out0_valid"}, 32'(bus.out0_valid), 32'(mq.size() > 0));
        chk({tag, "_out1_valid"}, 32'(bus.out1_valid), 32'(mq.size() > 0 && mq[0].pair));
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(model_ready(x)));
        if (mq.size() > 0) begin
            chk({tag, "_out0_pay"}, bus.out0_pay, mq[0].p0);
            if (mq[0].pair) chk({tag, "_out1_pay"}, bus.out1_pay, mq[0].p1);
        end
`ifdef PAIR_DISPATCH_STATS_EN
        chk({tag, "_pair_cnt"}, 32'(pair_cnt), 32'(m_pair));
        chk({tag, "_split_cnt"}, 32'(split_cnt), 32'(m_split));
`endif
    endtask

    task automatic model_step(input in_t x);
        bit   rdy;
        grp_t g;
        rdy = model_ready(x);
        if (mq.size() > 0 && x.out_ready) begin
            g = mq.pop_front();
            if (g.pair && m_pair < 65535) m_pair++;
            if (g.split_first && m_split < 65535) m_split++;
        end
        if (x.flush) begin
            mq.delete();
        end else if (x.in_valid && rdy) begin
            if (x.v0 && x.v1) begin
                if (!hazard(x)) begin
                    mq.push_back('{pair: 1'b1, split_first: 1'b0, p0: x.p0, p1: x.p1});
                end else begin
                    mq.push_back('{pair: 1'b0, split_first: 1'b1, p0: x.p0, p1: 32'h0});
                    mq.push_back('{pair: 1'b0, split_first: 1'b0, p0: x.p1, p1: 32'h0});
                end
            end else if (x.v0) begin
                mq.push_back('{pair: 1'b0, split_first: 1'b0, p0: x.p0, p1: 32'h0});
            end else if (x.v1) begin
                mq.push_back('{pair: 1'b0, split_first: 1'b0, p0: x.p1, p1: 32'h0});
            end
        end
    endtask

    task automatic run_model(input string tag, input in_t x);
        apply(x);
        model_check(tag, x);
        model_step(x);
    endtask

    initial begin
        in_t x;
        in_t k;

        // Directed table, out_ready held high, no flush
        vecs[0]  = mk(mk_in(1,1,1, 3,1,2, 7,5,6,   32'hA0, 32'hA1, 0, 1), 0, 0, 1, 0, 0);
        vecs[1]  = mk(mk_in(1,1,1, 3,1,2, 8,3,6,   32'hB0, 32'hB1, 0, 1), 1, 1, 1, 32'hA0, 32'hA1);
        vecs[2]  = mk(mk_in(1,1,1, 0,1,2, 9,0,0,   32'hC0, 32'hC1, 0, 1), 1, 0, 0, 32'hB0, 0);
        vecs[3]  = mk(mk_in(1,1,1, 0,1,2, 9,0,0,   32'hC0, 32'hC1, 0, 1), 1, 0, 1, 32'hB1, 0);
        vecs[4]  = mk(mk_in(1,0,1, 0,0,0, 5,1,1,   32'hD0, 32'hD1, 0, 1), 1, 1, 1, 32'hC0, 32'hC1);
        vecs[5]  = mk(idle(1),                                            1, 0, 1, 32'hD1, 0);
        vecs[6]  = mk(mk_in(1,1,1, 1,2,3, 4,5,6,   32'hE0, 32'hE1, 0, 1), 0, 0, 1, 0, 0);
        vecs[7]  = mk(mk_in(1,1,1, 2,1,1, 3,4,5,   32'hF0, 32'hF1, 0, 1), 1, 1, 1, 32'hE0, 32'hE1);
        vecs[8]  = mk(mk_in(1,1,1, 6,7,8, 9,10,11, 32'h60, 32'h61, 0, 1), 1, 1, 1, 32'hF0, 32'hF1);
        vecs[9]  = mk(mk_in(1,1,1, 12,0,0, 13,14,15, 32'h70, 32'h71, 0, 1), 1, 1, 1, 32'h60, 32'h61);
        vecs[10] = mk(idle(1),                                            1, 1, 1, 32'h70, 32'h71);
        vecs[11] = mk(mk_in(1,1,1, 0,1,2, 2,3,4,   32'h80, 32'h81, 0, 1), 0, 0, 1, 0, 0);
        vecs[12] = mk(mk_in(1,1,1, 4,5,6, 4,7,8,   32'h90, 32'h91, 0, 1), 1, 0, 0, 32'h80, 0);
        vecs[13] = mk(mk_in(1,1,1, 4,5,6, 4,7,8,   32'h90, 32'h91, 0, 1), 1, 0, 1, 32'h81, 0);
        vecs[14] = mk(idle(1),                                            1, 0, 0, 32'h90, 0);
        vecs[15] = mk(idle(1),                                            1, 0, 1, 32'h91, 0);
        vecs[16] = mk(idle(1),                                            0, 0, 1, 0, 0);

        x = idle(0);
        apply(x);
        apply(x);
        chk("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
        chk("rst_out0_pay", bus.out0_pay, 32'h0);
        chk("rst_out1_pay", bus.out1_pay, 32'h0);
        rst = 1'b0;
        apply(idle(1));
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef PAIR_DISPATCH_STATS_EN
        chk("rst_pair_cnt", 32'(pair_cnt), 32'd0);
        chk("rst_split_cnt", 32'(split_cnt), 32'd0);
`endif

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].x);
            chk($sformatf("vec%0d_out0_valid", i), 32'(bus.out0_valid), 32'(vecs[i].e_o0));
            chk($sformatf("vec%0d_out1_valid", i), 32'(bus.out1_valid), 32'(vecs[i].e_o1));
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
            if (vecs[i].e_o0) chk($sformatf("vec%0d_out0_pay", i), bus.out0_pay, vecs[i].e_p0);
            if (vecs[i].e_o1) chk($sformatf("vec%0d_out1_pay", i), bus.out1_pay, vecs[i].e_p1);
            model_step(vecs[i].x);
        end
`ifdef PAIR_DISPATCH_STATS_EN
        chk("table_pair_cnt", 32'(pair_cnt), 32'd6);
        chk("table_split_cnt", 32'(split_cnt), 32'd3);
`endif

        // Stall: pair held with out_ready low for five cycles
        k = mk_in(1,1,1, 1,2,3, 4,5,6, 32'h1111, 32'h2222, 0, 0);
        run_model("stall_accept", k);
        x = mk_in(1,1,1, 7,8,9, 10,11,12, 32'h3333, 32'h4444, 0, 0);
        for (int i = 0; i < 5; i++) begin
            run_model("stall", x);
            chk("stall_out0_pay", bus.out0_pay, 32'h1111);
            chk("stall_out1_pay", bus.out1_pay, 32'h2222);
            chk("stall_out1_valid", 32'(bus.out1_valid), 32'd1);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        run_model("stall_release", idle(1));
        run_model("stall_after", idle(1));
        chk("stall_after_empty", 32'(bus.out0_valid), 32'd0);

        // Flush while the second half of a split is pending
        run_model("flush_accept", mk_in(1,1,1, 5,1,2, 6,5,0, 32'h5550, 32'h5551, 0, 1));
        run_model("flush_first", idle(1));
        run_model("flush_second", mk_in(1,1,1, 1,2,3, 4,5,6, 32'h77, 32'h78, 1, 0));
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        run_model("flush_after", idle(0));
        chk("flush_out0_valid", 32'(bus.out0_valid), 32'd0);

        // Random traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            x = mk_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) != 0,
                      4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                      $urandom, $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
            run_model("rand", x);
        end

        // Asynchronous reset while a pair is held
        run_model("arst_accept", mk_in(1,1,1, 1,2,3, 4,5,6, 32'hDEAD, 32'hBEEF, 0, 0));
        apply(idle(0));
        chk("arst_pre_out0_valid", 32'(bus.out0_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_out0_valid", 32'(bus.out0_valid), 32'd0);
        chk("arst_out1_valid", 32'(bus.out1_valid), 32'd0);
        chk("arst_out0_pay", bus.out0_pay, 32'h0);
        rst = 1'b0;
        mq.delete();
        m_pair  = 0;
        m_split = 0;
        run_model("arst_after", idle(1));

`ifdef PAIR_DISPATCH_STATS_EN
        x = mk_in(1,1,1, 1,2,3, 4,5,6, 32'h1, 32'h2, 0, 1);
        for (int i = 0; i < 65540; i++) begin
            apply(x);
            model_step(x);
        end
        run_model("sat", idle(1));
        chk("sat_pair_cnt", 32'(pair_cnt), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
